// File: rtl/boron_key_schedule_engine_if.sv
// Handshake bundle between the Boron key-schedule engine and its user.
// The master side issues start/mode/key_in and drives rk_ready; the slave
// side (the engine) streams round keys back with rk_valid/rk_last.
interface boron_key_schedule_engine_if #(
  parameter int KEY_BITS = 80,
  parameter int CNT_W    = 5
);
  logic                start;
  logic                mode;
  logic [KEY_BITS-1:0] key_in;
  logic                rk_ready;
  logic [63:0]         rk;
  logic [CNT_W-1:0]    rk_idx;
  logic                rk_valid;
  logic                rk_last;
  logic                busy;

  modport master (
    output start, mode, key_in, rk_ready,
    input  rk, rk_idx, rk_valid, rk_last, busy
  );

  modport slave (
    input  start, mode, key_in, rk_ready,
    output rk, rk_idx, rk_valid, rk_last, busy
  );
endinterface

// File: rtl/boron_key_schedule_engine.sv
// Boron key-schedule engine: streams round keys K0..KN (encryption order)
// or KN..K0 (decryption order), one key per rk_valid/rk_ready handshake.
// Decryption order first runs the schedule forward to KN, then walks back
// with the inverse step, so no key table is stored.
// Optional feature macro: BORON_KS_DEC_EN enables decryption order (PREP
// state, inverse step, inverse S-box). Without it, mode is ignored and
// every start produces encryption order.
module boron_key_schedule_engine #(
  parameter int KEY_BITS   = 80,
  parameter int NUM_ROUNDS = 25,
  parameter int ROT        = 13,
  parameter int CNT_W      = 5
) (
  input logic                        clk,
  input logic                        rst,
  boron_key_schedule_engine_if.slave ks
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

`ifdef BORON_KS_DEC_EN
  typedef enum logic [1:0] {IDLE, PREP, RUN} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t              state_q, state_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_key;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hE;  4'h1: return 4'h4;  4'h2: return 4'hB;  4'h3: return 4'h1;
      4'h4: return 4'h7;  4'h5: return 4'h9;  4'h6: return 4'hC;  4'h7: return 4'hA;
      4'h8: return 4'hD;  4'h9: return 4'h2;  4'hA: return 4'h0;  4'hB: return 4'hF;
      4'hC: return 4'h8;  4'hD: return 4'h5;  4'hE: return 4'h3;  default: return 4'h6;
    endcase
  endfunction

  // Forward step: rotate left, substitute low nibble(s), fold in the counter.
  function automatic logic [KEY_BITS-1:0] fwd_step(input logic [KEY_BITS-1:0] k,
                                                   input logic [CNT_W-1:0]    c);
    logic [KEY_BITS-1:0] r;
    r = (k << ROT) | (k >> (KEY_BITS - ROT));
    r[3:0] = sbox(r[3:0]);
    if (KEY_BITS == 128) r[7:4] = sbox(r[7:4]);
    r[63:59] = r[63:59] ^ 5'(c);
    return r;
  endfunction

`ifdef BORON_KS_DEC_EN
  logic dec_q, dec_d;

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: return 4'hA;  4'h1: return 4'h3;  4'h2: return 4'h9;  4'h3: return 4'hE;
      4'h4: return 4'h1;  4'h5: return 4'hD;  4'h6: return 4'hF;  4'h7: return 4'h4;
      4'h8: return 4'hC;  4'h9: return 4'h5;  4'hA: return 4'h7;  4'hB: return 4'h2;
      4'hC: return 4'h6;  4'hD: return 4'h8;  4'hE: return 4'h0;  default: return 4'hB;
    endcase
  endfunction

  // Inverse step undoes fwd_step in reverse order: counter, S-box, rotate.
  function automatic logic [KEY_BITS-1:0] inv_step(input logic [KEY_BITS-1:0] k,
                                                   input logic [CNT_W-1:0]    c);
    logic [KEY_BITS-1:0] r;
    r = k;
    r[63:59] = r[63:59] ^ 5'(c);
    r[3:0] = sbox_inv(r[3:0]);
    if (KEY_BITS == 128) r[7:4] = sbox_inv(r[7:4]);
    return (r >> ROT) | (r << (KEY_BITS - ROT));
  endfunction
`else
  logic unused_mode;
  assign unused_mode = ks.mode;
`endif

  // State, key register, counter and direction flag; reset abandons any run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
`ifdef BORON_KS_DEC_EN
      dec_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
`ifdef BORON_KS_DEC_EN
      dec_q   <= dec_d;
`endif
    end
  end

  // Next-state, key stepping and handshake outputs.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
`ifdef BORON_KS_DEC_EN
    dec_d   = dec_q;
    last_key = dec_q ? (cnt_q == '0) : (cnt_q == LAST_CNT);
`else
    last_key = (cnt_q == LAST_CNT);
`endif

    ks.rk       = key_q[63:0];
    ks.rk_idx   = cnt_q;
    ks.rk_valid = (state_q == RUN);
    ks.rk_last  = (state_q == RUN) && last_key;
    ks.busy     = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (ks.start) begin
          key_d = ks.key_in;
          cnt_d = '0;
`ifdef BORON_KS_DEC_EN
          dec_d   = ks.mode;
          state_d = ks.mode ? PREP : RUN;
`else
          state_d = RUN;
`endif
        end
      end
`ifdef BORON_KS_DEC_EN
      PREP: begin
        key_d = fwd_step(key_q, cnt_q + ONE);
        cnt_d = cnt_q + ONE;
        if (cnt_q == LAST_CNT - ONE) state_d = RUN;
      end
`endif
      RUN: begin
        if (ks.rk_ready) begin
          if (last_key) begin
            state_d = IDLE;
`ifdef BORON_KS_DEC_EN
          end else if (dec_q) begin
            key_d = inv_step(key_q, cnt_q);
            cnt_d = cnt_q - ONE;
`endif
          end else begin
            key_d = fwd_step(key_q, cnt_q + ONE);
            cnt_d = cnt_q + ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_boron_key_schedule_engine.sv
// Self-checking bench for boron_key_schedule_engine: table of hand-computed
// round keys, full-sequence runs against a bit-level reference model, plus
// backpressure, start-while-busy, mid-run reset and a 128-bit instance.
// Honours BORON_KS_DEC_EN to choose the expected order for mode=1.
module tb_boron_key_schedule_engine;

  localparam int N     = 25;
  localparam int ROT   = 13;
  localparam int CNT_W = 5;
  localparam logic [3:0] SBOX [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                       4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};

  logic clk;
  logic rst;

  boron_key_schedule_engine_if #(.KEY_BITS(80),  .CNT_W(CNT_W)) if80 ();
  boron_key_schedule_engine_if #(.KEY_BITS(128), .CNT_W(CNT_W)) if128 ();

  boron_key_schedule_engine #(.KEY_BITS(80), .NUM_ROUNDS(N), .ROT(ROT), .CNT_W(CNT_W))
    dut80 (.clk(clk), .rst(rst), .ks(if80));
  boron_key_schedule_engine #(.KEY_BITS(128), .NUM_ROUNDS(N), .ROT(ROT), .CNT_W(CNT_W))
    dut128 (.clk(clk), .rst(rst), .ks(if128));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] key;
    int          steps;
    bit          chk_rk;
    logic [63:0] exp_rk;
    int          exp_idx;
    bit          exp_last;
  } vec_t;

  vec_t        vecs [10];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_k [0:N];
  logic [63:0] got_rk [$];
  int          got_idx [$];
  bit          got_last [$];
  int          first_valid;
  logic [79:0] rkey;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic apply_stimulus(input logic [79:0] key, input logic m);
    if80.key_in = key;
    if80.mode   = m;
    if80.start  = 1'b1;
    tick();
    if80.start  = 1'b0;
  endtask

  // Reference forward step, written bit by bit.
  function automatic logic [79:0] m_fwd(input logic [79:0] k, input int c);
    logic [79:0] r;
    logic [4:0]  cc;
    for (int j = 0; j < 80; j++) r[(j + ROT) % 80] = k[j];
    r[3:0] = SBOX[r[3:0]];
    cc = c[4:0];
    r[63:59] = r[63:59] ^ cc;
    return r;
  endfunction

  task automatic build_model(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    for (int i = 0; i <= N; i++) begin
      if (i > 0) k = m_fwd(k, i);
      exp_k[i] = k[63:0];
    end
  endtask

  // Gather one key sequence; optional random stalls and a start pulse mid-run.
  task automatic collect(input bit stall, input int poke_cyc, input logic [79:0] poke_key);
    logic [63:0]      prev_rk;
    logic [CNT_W-1:0] prev_idx;
    bit held, done;
    got_rk.delete(); got_idx.delete(); got_last.delete();
    held = 0; done = 0; first_valid = -1;
    prev_rk = '0; prev_idx = '0;
    for (int cyc = 0; cyc < 120 && !done; cyc++) begin
      if (held) begin
        check_output("stall rk stable", if80.rk, prev_rk);
        check_output("stall idx stable", 64'(if80.rk_idx), 64'(prev_idx));
      end
      if (cyc == poke_cyc) begin
        if80.start = 1'b1; if80.key_in = poke_key; if80.mode = ~if80.mode;
      end else begin
        if80.start = 1'b0;
      end
      if80.rk_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      held = 0;
      if (if80.rk_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (if80.rk_ready) begin
          got_rk.push_back(if80.rk);
          got_idx.push_back(int'(if80.rk_idx));
          got_last.push_back(if80.rk_last);
          if (if80.rk_last) done = 1;
        end else begin
          held = 1; prev_rk = if80.rk; prev_idx = if80.rk_idx;
        end
      end
      tick();
    end
    if80.start = 1'b0;
    if80.rk_ready = 1'b0;
    if (!done) check_output("collect timeout (no rk_last)", 64'(got_rk.size()), 64'(N + 1));
    check_output("busy after last", 64'(if80.busy), 64'd0);
  endtask

  task automatic verify_stream(input string name, input bit reversed);
    int e;
    check_output({name, " length"}, 64'(got_rk.size()), 64'(N + 1));
    for (int j = 0; j < got_rk.size() && j <= N; j++) begin
      e = reversed ? N - j : j;
      check_output($sformatf("%s rk[%0d]", name, j), got_rk[j], exp_k[e]);
      check_output($sformatf("%s idx[%0d]", name, j), 64'(got_idx[j]), 64'(e));
      check_output($sformatf("%s last[%0d]", name, j), 64'(got_last[j]), 64'(j == N));
    end
  endtask

  task automatic check_zero_outputs(input string name);
    check_output({name, " rk"}, if80.rk, 64'd0);
    check_output({name, " rk_idx"}, 64'(if80.rk_idx), 64'd0);
    check_output({name, " rk_valid"}, 64'(if80.rk_valid), 64'd0);
    check_output({name, " rk_last"}, 64'(if80.rk_last), 64'd0);
    check_output({name, " busy"}, 64'(if80.busy), 64'd0);
  endtask

  initial begin
    logic m128;
    vecs[0] = '{80'h0, 0, 1'b1, 64'h0, 0, 1'b0};
    vecs[1] = '{80'h0, 1, 1'b1, 64'h0800_0000_0000_000E, 1, 1'b0};
    vecs[2] = '{80'h0, 2, 1'b1, 64'h1000_0000_0001_C00E, 2, 1'b0};
    vecs[3] = '{80'h0, 3, 1'b1, 64'h1800_0000_3801_C02E, 3, 1'b0};
    vecs[4] = '{80'hFFFF_FFFF_FFFF_FFFF_FFFF, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0};
    vecs[5] = '{80'hFFFF_FFFF_FFFF_FFFF_FFFF, 1, 1'b1, 64'hF7FF_FFFF_FFFF_FFF6, 1, 1'b0};
    vecs[6] = '{80'h1, 1, 1'b1, 64'h0800_0000_0000_200E, 1, 1'b0};
    vecs[7] = '{80'hABCD_0123_4567_89AB_CDEF, 0, 1'b1, 64'h0123_4567_89AB_CDEF, 0, 1'b0};
    vecs[8] = '{80'h0, 24, 1'b0, 64'h0, 24, 1'b0};
    vecs[9] = '{80'h0, 25, 1'b0, 64'h0, 25, 1'b1};

    if80.start = 0; if80.mode = 0; if80.key_in = '0; if80.rk_ready = 0;
    if128.start = 0; if128.mode = 0; if128.key_in = '0; if128.rk_ready = 0;
    rst = 1'b1;
    tick(); tick();
    check_zero_outputs("reset");
    rst = 1'b0;
    tick();

    $display("[TB] directed vector table");
    foreach (vecs[v]) begin
      apply_stimulus(vecs[v].key, 1'b0);
      for (int s = 0; s < vecs[v].steps; s++) begin
        if80.rk_ready = 1'b1;
        tick();
      end
      if80.rk_ready = 1'b0;
      if (vecs[v].chk_rk) check_output($sformatf("vec%0d rk", v), if80.rk, vecs[v].exp_rk);
      check_output($sformatf("vec%0d idx", v), 64'(if80.rk_idx), 64'(vecs[v].exp_idx));
      check_output($sformatf("vec%0d last", v), 64'(if80.rk_last), 64'(vecs[v].exp_last));
      check_output($sformatf("vec%0d valid", v), 64'(if80.rk_valid), 64'd1);
      if80.rk_ready = 1'b1;
      for (int c = 0; c < 40 && if80.busy; c++) tick();
      if80.rk_ready = 1'b0;
      check_output($sformatf("vec%0d drain", v), 64'(if80.busy), 64'd0);
    end

    $display("[TB] zero key full encryption run");
    build_model(80'h0);
    apply_stimulus(80'h0, 1'b0);
    collect(1'b0, -1, 80'h0);
    verify_stream("enc zero", 1'b0);
    check_output("enc zero first valid", 64'(first_valid), 64'd0);

    $display("[TB] back-to-back random key run");
    rkey = {16'($urandom), $urandom, $urandom};
    build_model(rkey);
    apply_stimulus(rkey, 1'b0);
    collect(1'b0, -1, 80'h0);
    verify_stream("enc rand", 1'b0);

    $display("[TB] backpressure");
    apply_stimulus(rkey, 1'b0);
    collect(1'b1, -1, 80'h0);
    verify_stream("enc stall", 1'b0);

    $display("[TB] start while busy");
    apply_stimulus(rkey, 1'b0);
    collect(1'b0, 7, ~rkey);
    verify_stream("enc poke", 1'b0);

`ifdef BORON_KS_DEC_EN
    $display("[TB] decryption round trip");
    apply_stimulus(rkey, 1'b1);
    collect(1'b0, -1, 80'h0);
    verify_stream("dec", 1'b1);
    check_output("dec first valid", 64'(first_valid), 64'(N));
`else
    $display("[TB] mode=1 without decryption support");
    apply_stimulus(rkey, 1'b1);
    collect(1'b0, -1, 80'h0);
    verify_stream("mode1 enc", 1'b0);
    check_output("mode1 first valid", 64'(first_valid), 64'd0);
`endif

    $display("[TB] reset mid-operation");
    apply_stimulus(rkey, 1'b1);
    if80.rk_ready = 1'b1;
    for (int c = 0; c < 5; c++) tick();
`ifdef BORON_KS_DEC_EN
    check_output("prep no valid", 64'(if80.rk_valid), 64'd0);
`endif
    rst = 1'b1;
    tick();
    check_zero_outputs("rst prep");
    rst = 1'b0;
    if80.rk_ready = 1'b0;
    apply_stimulus(rkey, 1'b0);
    if80.rk_ready = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    check_output("run before rst idx", 64'(if80.rk_idx), 64'd3);
    rst = 1'b1;
    tick();
    check_zero_outputs("rst run");
    rst = 1'b0;
    if80.rk_ready = 1'b0;
    apply_stimulus(rkey, 1'b0);
    collect(1'b0, -1, 80'h0);
    verify_stream("after rst", 1'b0);

    $display("[TB] 128-bit instance");
`ifdef BORON_KS_DEC_EN
    m128 = 1'b0;
`else
    m128 = 1'b1;
`endif
    if128.key_in = '0; if128.mode = m128; if128.start = 1'b1;
    tick();
    if128.start = 1'b0;
    check_output("k128 valid", 64'(if128.rk_valid), 64'd1);
    check_output("k128 K0", if128.rk, 64'h0);
    if128.rk_ready = 1'b1;
    tick();
    if128.rk_ready = 1'b0;
    check_output("k128 K1", if128.rk, 64'h0800_0000_0000_00EE);
    check_output("k128 idx", 64'(if128.rk_idx), 64'd1);
    if128.rk_ready = 1'b1;
    for (int c = 0; c < 40 && if128.busy; c++) tick();
    if128.rk_ready = 1'b0;
    check_output("k128 done", 64'(if128.busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/boron_key_schedule_engine.md
# boron_key_schedule_engine

Sequential, parametrised Boron key-schedule engine that streams round keys to the round datapath, one key per handshake. It replaces the per-round combinational decryption-key step with a single block serving both directions. Encryption mode generates K0..KN forward. Decryption mode first runs the schedule forward to KN, then walks it backwards with the inverse step, so the decryption datapath receives KN..K0 without a stored key table.

## Interface
- KEY_BITS, 80: master key width; legal values 80 and 128.
- NUM_ROUNDS, 25: number of counter-driven schedule steps N; N+1 round keys are emitted.
- ROT, 13: key-register rotate amount per step.
- CNT_W, 5: round-counter width; NUM_ROUNDS < 2^CNT_W.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle request; accepted only in IDLE.
- mode  in  1  sampled with start: 0 = encryption order, 1 = decryption order.
- key_in  in  KEY_BITS  master key, sampled with start.
- rk_ready  in  1  consumer accepts rk this cycle.
- rk  out  64  current round key, equal to key_reg[63:0].
- rk_idx  out  CNT_W  index i of the key on rk (Ki).
- rk_valid  out  1  rk/rk_idx are valid.
- rk_last  out  1  high with rk_valid on the final key of the sequence.
- busy  out  1  high in any state other than IDLE.

## Operation
- S-box S = {E,4,B,1,7,9,C,A,D,2,0,F,8,5,3,6}; S⁻¹ is its inverse. S-box width: nibble [3:0] when KEY_BITS=80; nibbles [3:0] and [7:4] when KEY_BITS=128.
- Forward step with counter c: rotate key_reg left by ROT, apply S to the low nibble(s), then XOR c into bits [63:59]. K(i) = F(K(i-1), i) for i = 1..N; K0 = key_in.
- Inverse step with counter c: XOR c into [63:59], apply S⁻¹ to the low nibble(s), then rotate right by ROT. K(i-1) = G(K(i), i).
- c is zero-extended or truncated to 5 bits before the XOR.
- State IDLE: rk_valid=0. On start: load key_reg=key_in and cnt=0.
  - mode=0: go to RUN.
  - mode=1: go to PREP.
- State PREP (decryption only): one forward step per cycle, cnt counting 1..N. After the N-th step, go to RUN with cnt=N. PREP never asserts rk_valid.
- State RUN: rk_valid=1 and rk_idx=cnt.
  - On rk_valid && rk_ready, key_reg takes one step and cnt moves one position.
  - Encryption: forward step F(key_reg, cnt+1), then cnt+1.
  - Decryption: inverse step G(key_reg, cnt), then cnt-1.
  - Without rk_ready, rk, rk_idx and rk_last hold stable.
- rk_last = rk_valid && (enc ? cnt==N : cnt==0). The handshake on the last key returns the engine to IDLE, and key_reg is not stepped.
- start while busy is ignored; it has no effect on any state.
- rst in any state: go to IDLE immediately, abandoning any sequence in progress.

## Timing
- Reset values: rk=0, rk_idx=0, rk_valid=0, rk_last=0, busy=0; key_reg=0, cnt=0.
- Encryption: start at edge t gives rk_valid=1 with K0 after edge t+1. Each key is visible one cycle after the previous handshake.
- Decryption: PREP lasts exactly N cycles. KN is on rk after edge t+1+N.
- Sustained throughput is 1 key/cycle with rk_ready held high. A full encryption run is N+1 cycles in RUN.
- busy deasserts on the cycle after the last handshake. A start asserted in that same cycle is accepted.

## Configuration
- BORON_KS_DEC_EN defined: PREP state, inverse-step logic and S⁻¹ are present; mode behaves as above.
- BORON_KS_DEC_EN undefined: mode is ignored and every start runs encryption order. PREP, the inverse step and S⁻¹ are not synthesised.

## Test plan
- Zero key, encryption order:
  - key_in=0, mode=0, rk_ready=1: K0=64'h0.
  - K1=64'h0800_0000_0000_000E (S(0)=E, c=1 at bit 59).
  - 26 keys in total; rk_last is on rk_idx=25.
- Round trip: random 80-bit key, run mode=0 and record K0..K25. Then run mode=1 with the same key: it must emit exactly K25..K0, with rk_valid first high 26 cycles after start.
- Backpressure:
  - Toggle rk_ready randomly during encryption: rk/rk_idx must stay stable while rk_ready=0.
  - The sequence must be identical to the unstalled run.
- Start while busy: pulse start with a different key_in mid-sequence; the output stream must be unchanged.
- Reset mid-operation:
  - Assert rst during PREP and again during RUN: all outputs must be 0 on the next cycle.
  - A new start must produce a correct sequence.
- KEY_BITS=128, BORON_KS_DEC_EN undefined: mode=1 must still yield encryption order. K1[7:0]=8'hEE for key_in=0.
